// File: rtl/button_event_fsm.sv
// button_event_fsm
// Turns one debounced, clock-synchronous button level into registered
// single-cycle event strobes: press, release, short press, long press and
// auto-repeat while held. One instance per button.

module button_event_fsm #(
  parameter logic ACTIVE_LEVEL     = 1'b1,
  parameter int   LONG_PRESS_LIMIT = 25000000,
  parameter int   REPEAT_LIMIT     = 6250000,
  parameter logic REPEAT_EN        = 1'b1
) (
  input  logic i_Clk,
  input  logic i_Rst_L,
  input  logic i_Switch,
  output logic o_Pressed,
  output logic o_Press_Pulse,
  output logic o_Release_Pulse,
  output logic o_Short_Pulse,
  output logic o_Long_Pulse,
  output logic o_Repeat_Pulse
);

  // One shared counter times both the long-press hold and the repeat period,
  // so it is sized for the larger of the two limits.
  localparam int MAX_LIMIT = (LONG_PRESS_LIMIT > REPEAT_LIMIT) ? LONG_PRESS_LIMIT : REPEAT_LIMIT;
  localparam int CNT_W     = $clog2(MAX_LIMIT + 1);

  localparam logic [CNT_W-1:0] LONG_LAST   = CNT_W'(LONG_PRESS_LIMIT - 1);
  localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_LIMIT - 1);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_PRESSED = 2'b01,
    ST_HELD    = 2'b10
  } state_t;

  state_t           state_reg;
  state_t           state_next;
  logic [CNT_W-1:0] count_reg;
  logic [CNT_W-1:0] count_next;
  logic             pressed_next;
  logic             press_next;
  logic             release_next;
  logic             short_next;
  logic             long_next;
  logic             repeat_next;
  logic             act;

  assign act = (i_Switch == ACTIVE_LEVEL);

  // Next-state, counter and strobe decode; strobes default low every cycle.
  always_comb begin
    state_next   = state_reg;
    count_next   = count_reg;
    press_next   = 1'b0;
    release_next = 1'b0;
    short_next   = 1'b0;
    long_next    = 1'b0;
    repeat_next  = 1'b0;

    case (state_reg)
      ST_IDLE: begin
        count_next = '0;
        if (act) begin
          state_next = ST_PRESSED;
          press_next = 1'b1;
        end
      end

      ST_PRESSED: begin
        // Release takes priority over reaching the long-press point.
        if (!act) begin
          state_next   = ST_IDLE;
          count_next   = '0;
          release_next = 1'b1;
          short_next   = 1'b1;
        end else if (count_reg == LONG_LAST) begin
          state_next = ST_HELD;
          count_next = '0;
          long_next  = 1'b1;
        end else begin
          count_next = count_reg + 1'b1;
        end
      end

      ST_HELD: begin
        // Release takes priority over a repeat tick; no short strobe here.
        if (!act) begin
          state_next   = ST_IDLE;
          count_next   = '0;
          release_next = 1'b1;
        end else if (count_reg == REPEAT_LAST) begin
          count_next  = '0;
          repeat_next = REPEAT_EN;
        end else begin
          count_next = count_reg + 1'b1;
        end
      end

      default: begin
        // Unused encoding: fall back to IDLE quietly.
        state_next = ST_IDLE;
        count_next = '0;
      end
    endcase

    pressed_next = (state_next == ST_PRESSED) || (state_next == ST_HELD);
  end

  // State, counter and registered outputs; reset clears everything at once.
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      state_reg       <= ST_IDLE;
      count_reg       <= '0;
      o_Pressed       <= 1'b0;
      o_Press_Pulse   <= 1'b0;
      o_Release_Pulse <= 1'b0;
      o_Short_Pulse   <= 1'b0;
      o_Long_Pulse    <= 1'b0;
      o_Repeat_Pulse  <= 1'b0;
    end else begin
      state_reg       <= state_next;
      count_reg       <= count_next;
      o_Pressed       <= pressed_next;
      o_Press_Pulse   <= press_next;
      o_Release_Pulse <= release_next;
      o_Short_Pulse   <= short_next;
      o_Long_Pulse    <= long_next;
      o_Repeat_Pulse  <= repeat_next;
    end
  end

endmodule

// File: tb/tb_button_event_fsm.sv
// Testbench for button_event_fsm. Two instances: an active-high button with
// auto-repeat (LONG=8, REPEAT=4) and an active-low button without it
// (LONG=6, REPEAT=3). Expected strobes are derived from press length and
// pushed to a queue; the monitor pops one entry per strobe it observes.

module tb_button_event_fsm;

  localparam int LONG_A = 8;
  localparam int REP_A  = 4;
  localparam int LONG_B = 6;
  localparam int REP_B  = 3;

  logic clk;
  logic rst_n;
  logic sw_a, sw_b;
  logic pressed_a, press_a, release_a, short_a, long_a, repeat_a;
  logic pressed_b, press_b, release_b, short_b, long_b, repeat_b;

  int cyc    = 0;
  int checks = 0;
  int errors = 0;
  int pcnt_a = 0;
  int pcnt_b = 0;

  // kind = dut*5 + strobe (0 press, 1 release, 2 short, 3 long, 4 repeat)
  typedef struct {
    int kind;
    int edge_idx;
  } ev_t;

  ev_t exp_q[$];

  button_event_fsm #(
    .ACTIVE_LEVEL(1'b1), .LONG_PRESS_LIMIT(LONG_A), .REPEAT_LIMIT(REP_A), .REPEAT_EN(1'b1)
  ) dut_a (
    .i_Clk(clk), .i_Rst_L(rst_n), .i_Switch(sw_a),
    .o_Pressed(pressed_a), .o_Press_Pulse(press_a), .o_Release_Pulse(release_a),
    .o_Short_Pulse(short_a), .o_Long_Pulse(long_a), .o_Repeat_Pulse(repeat_a)
  );

  button_event_fsm #(
    .ACTIVE_LEVEL(1'b0), .LONG_PRESS_LIMIT(LONG_B), .REPEAT_LIMIT(REP_B), .REPEAT_EN(1'b0)
  ) dut_b (
    .i_Clk(clk), .i_Rst_L(rst_n), .i_Switch(sw_b),
    .o_Pressed(pressed_b), .o_Press_Pulse(press_b), .o_Release_Pulse(release_b),
    .o_Short_Pulse(short_b), .o_Long_Pulse(long_b), .o_Repeat_Pulse(repeat_b)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Edge index: at a negedge, cyc is the number of the posedge just past.
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (edge %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic void push_ev(input int kind, input int edge_idx);
    ev_t e;
    e.kind     = kind;
    e.edge_idx = edge_idx;
    exp_q.push_back(e);
  endfunction

  // Expected strobes for a press whose first active edge is pe, held n edges.
  function automatic void push_events(input int dut, input int pe, input int n);
    int lim;
    int rep;
    bit ren;
    lim = (dut == 0) ? LONG_A : LONG_B;
    rep = (dut == 0) ? REP_A : REP_B;
    ren = (dut == 0);
    push_ev(dut*5 + 0, pe);
    if (n > lim) begin
      push_ev(dut*5 + 3, pe + lim);
      if (ren)
        for (int e = pe + lim + rep; e < pe + n; e += rep)
          push_ev(dut*5 + 4, e);
    end
    push_ev(dut*5 + 1, pe + n);
    if (n <= lim) push_ev(dut*5 + 2, pe + n);
  endfunction

  // Monitor: every observed strobe must match the head of the queue.
  always @(negedge clk) begin
    logic [9:0] v;
    ev_t e;
    v = {repeat_b, long_b, short_b, release_b, press_b,
         repeat_a, long_a, short_a, release_a, press_a};
    for (int k = 0; k < 10; k++) begin
      if (v[k]) begin
        if (exp_q.size() == 0) begin
          check("unexpected_strobe", k, -1);
        end else begin
          e = exp_q.pop_front();
          check("strobe_kind", k, e.kind);
          check("strobe_edge", cyc, e.edge_idx);
        end
      end
    end
    if (pressed_a) pcnt_a++;
    if (pressed_b) pcnt_b++;
  end

  task automatic do_press(input int dut, input int n);
    int pe;
    int base;
    @(negedge clk);
    pe   = cyc + 1;
    base = (dut == 0) ? pcnt_a : pcnt_b;
    push_events(dut, pe, n);
    if (dut == 0) sw_a = 1'b1; else sw_b = 1'b0;
    repeat (n) @(negedge clk);
    if (dut == 0) sw_a = 1'b0; else sw_b = 1'b1;
    repeat (4) @(negedge clk);
    check("pressed_cycles", ((dut == 0) ? pcnt_a : pcnt_b) - base, n);
    $display("press dut=%0d hold=%0d press_edge=%0d", dut, n, pe);
  endtask

  task automatic check_a_clear(input string tag);
    check(tag, int'({pressed_a, press_a, release_a, short_a, long_a, repeat_a}), 0);
  endtask

  initial begin
    int pe;
    int base;
    rst_n = 1'b0;
    sw_a  = 1'b1;  // held through reset
    sw_b  = 1'b1;  // idle for active-low button

    // Reset with button held: outputs stay low, press strobe after release.
    repeat (3) @(negedge clk);
    check_a_clear("reset_outputs_a");
    check("reset_outputs_b", int'({pressed_b, press_b, release_b, short_b, long_b, repeat_b}), 0);
    pe   = cyc + 1;
    base = pcnt_a;
    push_events(0, pe, 3);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    sw_a = 1'b0;
    repeat (4) @(negedge clk);
    check("pressed_cycles", pcnt_a - base, 3);
    $display("press dut=0 hold=3 press_edge=%0d (held through reset)", pe);

    do_press(0, 5);    // short press
    do_press(0, 20);   // long press with two repeats
    do_press(0, LONG_A);            // release on long-limit edge
    do_press(0, LONG_A + 2*REP_A);  // release on repeat-limit edge
    do_press(0, 1);    // minimum press
    do_press(1, 20);   // active-low, no repeat

    // Asynchronous reset mid-HELD, between clock edges.
    @(negedge clk);
    pe = cyc + 1;
    push_ev(0, pe);
    push_ev(3, pe + LONG_A);
    sw_a = 1'b1;
    repeat (11) @(negedge clk);
    check("held_before_reset", int'(pressed_a), 1);
    #2 rst_n = 1'b0;
    #1;
    check_a_clear("async_reset_outputs");
    check("async_reset_count", int'(dut_a.count_reg), 0);
    check("async_reset_state", int'(dut_a.state_reg), 0);
    repeat (2) @(negedge clk);
    check("reset_hold_state", int'(dut_a.state_reg), 0);
    $display("async reset mid-hold press_edge=%0d", pe);

    // Button still held: a fresh press follows reset release.
    pe   = cyc + 1;
    base = pcnt_a;
    push_events(0, pe, 3);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    sw_a = 1'b0;
    repeat (4) @(negedge clk);
    check("pressed_cycles", pcnt_a - base, 3);
    $display("press dut=0 hold=3 press_edge=%0d (after async reset)", pe);

    repeat (5) @(negedge clk);
    check("queue_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/button_event_fsm.md
Name: button_event_fsm

Overview:
- Sits directly downstream of the switch debouncer.
- Consumes one debounced, registered button level and converts it into single-cycle event strobes: press, release, short-press, long-press and auto-repeat.
- Strobes drive the seven-segment digit counter logic, e.g. increment on short press and fast-step while held.
- One instance per button.

Parameters:
- ACTIVE_LEVEL, 1, logic level of i_Switch that means "pressed" (1 or 0).
- LONG_PRESS_LIMIT, 25000000, i_Clk cycles a press must be held before the long-press strobe (1 s at 25 MHz); legal range >= 2.
- REPEAT_LIMIT, 6250000, i_Clk cycles between auto-repeat strobes once long-press is reached (250 ms at 25 MHz); legal range >= 2.
- REPEAT_EN, 1, 1 = auto-repeat strobes enabled; 0 = o_Repeat_Pulse is tied low.

Ports:
- i_Clk  input  1  system clock.
- i_Rst_L  input  1  asynchronous, active-low reset.
- i_Switch  input  1  debounced button level. Already synchronous to i_Clk; no further synchronisation is done here.
- o_Pressed  output  1  registered level: 1 while the FSM is in PRESSED or HELD.
- o_Press_Pulse  output  1  one-cycle strobe on press.
- o_Release_Pulse  output  1  one-cycle strobe on any release.
- o_Short_Pulse  output  1  one-cycle strobe on release before the long-press point.
- o_Long_Pulse  output  1  one-cycle strobe when the hold reaches LONG_PRESS_LIMIT.
- o_Repeat_Pulse  output  1  one-cycle strobe every REPEAT_LIMIT cycles while in HELD.

Behaviour:
- Active signal: act = (i_Switch == ACTIVE_LEVEL).
- Counter: single counter r_Count, width $clog2(max(LONG_PRESS_LIMIT, REPEAT_LIMIT)+1).
- Reset (i_Rst_L low, asynchronous, no clock needed):
  - state = IDLE, r_Count = 0.
  - All outputs = 0.
  - Release of reset is synchronous to i_Clk.
- Registering: all outputs are registered. Every strobe is high for exactly one cycle, in the cycle following the clock edge at which its event is decided. Strobes default to 0 on every edge unless set below.
- IDLE:
  - act = 1 -> PRESSED; r_Count <= 0; o_Press_Pulse <= 1; o_Pressed <= 1.
  - Otherwise stay in IDLE; r_Count <= 0.
- PRESSED:
  - act = 0 -> IDLE; o_Release_Pulse <= 1; o_Short_Pulse <= 1; o_Pressed <= 0.
  - Else if r_Count == LONG_PRESS_LIMIT-1 -> HELD; r_Count <= 0; o_Long_Pulse <= 1.
  - Else r_Count <= r_Count + 1.
- HELD:
  - act = 0 -> IDLE; o_Release_Pulse <= 1 (no short pulse); o_Pressed <= 0.
  - Else if r_Count == REPEAT_LIMIT-1: r_Count <= 0; o_Repeat_Pulse <= REPEAT_EN.
  - Else r_Count <= r_Count + 1.
- Latency:
  - Press strobe appears 1 cycle after the first edge that samples act = 1.
  - Long strobe edge is exactly LONG_PRESS_LIMIT edges after the press edge.
  - First repeat edge is REPEAT_LIMIT edges after the long edge; later repeats are periodic at REPEAT_LIMIT.
- Simultaneous events: release on the same edge as a limit match -> release wins. No long or repeat strobe is issued; the counter is discarded.
- Minimum press: a one-cycle act pulse gives a press strobe then release+short strobes on consecutive cycles. Legal, because upstream debouncing guarantees stability.
- Mutual exclusion: o_Press_Pulse and o_Release_Pulse are never high in the same cycle. At most one of short, long and repeat is high in any cycle.
- Counter wrap: r_Count never exceeds max(LIMIT)-1, so no overflow is possible.
- Reset mid-press: all outputs drop immediately. The FSM is in IDLE after reset; if the button is still held, a fresh press strobe occurs on the first edge after reset release.
- Illegal state encoding: recovers to IDLE on the next edge with all strobes 0.

Test Plan:
- Reset with i_Switch held pressed, LONG=8, REPEAT=4: all outputs 0 during reset. o_Press_Pulse high for 1 cycle, 1 cycle after the first edge after reset release.
- Press held for 5 cycles then released, LONG=8: one press strobe, then release+short strobes together exactly once, no long strobe; o_Pressed high for 5 cycles.
- Press held for 20 cycles, LONG=8, REPEAT=4: long strobe 8 cycles after press strobe; repeat strobes at +4 and +8 after long (REPEAT_EN=1); on release, a release strobe only, no short.
- Release on the exact edge where r_Count == LONG-1: release+short strobes, no long strobe. Release on a repeat-limit edge: release strobe only, no repeat.
- ACTIVE_LEVEL=0, REPEAT_EN=0, 20-cycle low pulse: press/long/release strobes as for an active-high press; o_Repeat_Pulse stays 0 throughout.
- Assert i_Rst_L low asynchronously mid-HELD, between clock edges: outputs clear before the next edge; r_Count = 0 and the FSM is in IDLE afterwards.
